// File: rtl/relu_collector_floating_point32.sv
`default_nettype none
// ============================================================================
// Module   : relu_collector_floating_point32
// Brief    : Two-stage ReLU on serial FP32 neuron sums, packed into a
//            NUM_NODES-wide layer-output vector with a completion pulse.
// Revision : 1.0 - initial release
// ============================================================================
module relu_collector_floating_point32 #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_NODES  = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_valid,
    input  logic [DATA_WIDTH-1:0]           i_data,
    input  logic                            i_clear,
    output logic [NUM_NODES*DATA_WIDTH-1:0] o_data,
    output logic                            o_valid,
    output logic [$clog2(NUM_NODES+1)-1:0]  o_count
);

    localparam int             CW         = $clog2(NUM_NODES + 1);
    localparam logic [CW-1:0]  C_LAST_IDX = CW'(NUM_NODES - 1);
    localparam int             BUF_W      = (NUM_NODES - 1) * DATA_WIDTH;

    logic [CW-1:0]                  r_idx;
    logic                           r_s1_valid;
    logic                           r_s1_last;
    logic [CW-1:0]                  r_s1_slot;
    logic [DATA_WIDTH-1:0]          r_s1_data;
    logic [BUF_W-1:0]               r_buf;
    logic [NUM_NODES*DATA_WIDTH-1:0] r_out;
    logic                           r_out_valid;

    logic [DATA_WIDTH-1:0]          w_relu;
    logic                           w_accept;
    logic                           w_is_last;
    logic                           w_complete;

    // Any sign-set word (including -0, -Inf, negative NaN) clamps to +0.
    assign w_relu     = i_data[DATA_WIDTH-1] ? '0 : i_data;
    assign w_accept   = i_valid && !i_clear;
    assign w_is_last  = (r_idx == C_LAST_IDX);
    assign w_complete = r_s1_valid && r_s1_last;

    // Slot counter and stage-1 register; clear kills only what is entering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_slot  <= '0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (i_clear) begin
                r_idx <= '0;
            end else if (i_valid) begin
                r_s1_data <= w_relu;
                r_s1_slot <= r_idx;
                r_s1_last <= w_is_last;
                r_idx     <= w_is_last ? '0 : r_idx + 1'b1;
            end
        end
    end

    // The last slot is never stored; it goes straight into the output vector.
    generate
        for (genvar k = 0; k < NUM_NODES - 1; k++) begin : g_slot
            localparam logic [CW-1:0] C_K = CW'(k);
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_buf[k*DATA_WIDTH +: DATA_WIDTH] <= '0;
                end else if (r_s1_valid && !r_s1_last && (r_s1_slot == C_K)) begin
                    r_buf[k*DATA_WIDTH +: DATA_WIDTH] <= r_s1_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_complete;
            if (w_complete) begin
                r_out <= {r_s1_data, r_buf};
            end
        end
    end

    assign o_data  = r_out;
    assign o_valid = r_out_valid;
    assign o_count = r_idx;

endmodule
`default_nettype wire
